// File: rtl/muldiv_sequencer_pkg.sv
// muldiv_sequencer_pkg: shared state encoding, M-extension funct3 codes and multiplier modes.
package muldiv_sequencer_pkg;
  typedef enum logic [2:0] {IDLE, MUL_RUN, DIV_START, DIV_RUN, RESULT} muldiv_state_t;
  localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
  localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;
  localparam logic [1:0] MUL_UU = 2'd0, MUL_SS = 2'd1, MUL_SU = 2'd2;
  function automatic logic [1:0] mul_type_of(input logic [2:0] f);
    return f == MULHSU ? MUL_SU : f == MULHU ? MUL_UU : MUL_SS;
  endfunction
endpackage

// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if: issue, multiplier, divider and CDB signals of the mul/div sequencer.
interface muldiv_sequencer_if #(parameter int ROB_IDX_W = 5, parameter int PHYS_W = 6);
  logic                 flush;
  logic                 issue_valid, issue_ready, issue_regf_we;
  logic [2:0]           issue_funct3;
  logic [31:0]          issue_a, issue_b;
  logic [PHYS_W-1:0]    issue_phys_rd;
  logic [ROB_IDX_W-1:0] issue_rob_index;
  logic                 mul_start, mul_done;
  logic [1:0]           mul_type;
  logic [31:0]          mul_a, mul_b;
  logic [63:0]          mul_p;
  logic                 div_start, div_complete;
  logic [31:0]          div_a, div_b, div_quotient, div_remainder;
  logic                 cdb_valid, cdb_ready, cdb_regf_we;
  logic [31:0]          cdb_data;
  logic [PHYS_W-1:0]    cdb_phys_rd;
  logic [ROB_IDX_W-1:0] cdb_rob_index;
  modport master (
    input  flush, issue_valid, issue_regf_we, issue_funct3, issue_a, issue_b, issue_phys_rd,
           issue_rob_index, mul_p, mul_done, div_quotient, div_remainder, div_complete, cdb_ready,
    output issue_ready, mul_start, mul_type, mul_a, mul_b, div_start, div_a, div_b,
           cdb_valid, cdb_data, cdb_phys_rd, cdb_rob_index, cdb_regf_we
  );
  modport slave (
    output flush, issue_valid, issue_regf_we, issue_funct3, issue_a, issue_b, issue_phys_rd,
           issue_rob_index, mul_p, mul_done, div_quotient, div_remainder, div_complete, cdb_ready,
    input  issue_ready, mul_start, mul_type, mul_a, mul_b, div_start, div_a, div_b,
           cdb_valid, cdb_data, cdb_phys_rd, cdb_rob_index, cdb_regf_we
  );
endinterface

// File: rtl/muldiv_sign_fix.sv
// muldiv_sign_fix: RISC-V divide special cases, operand magnitudes and result sign restore.
module muldiv_sign_fix (
  input  logic [1:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [31:0] quo_i,
  input  logic [31:0] rem_i,
  output logic        special_o,
  output logic [31:0] special_val_o,
  output logic [31:0] abs_a_o,
  output logic [31:0] abs_b_o,
  output logic [31:0] result_o
);
  logic is_rem, neg_a, neg_b, ovf;
  // op_i is funct3[1:0]: bit1 selects remainder, bit0 selects unsigned
  assign is_rem        = op_i[1];
  assign neg_a         = !op_i[0] && a_i[31];
  assign neg_b         = !op_i[0] && b_i[31];
  assign ovf           = !op_i[0] && a_i == 32'h8000_0000 && b_i == 32'hFFFF_FFFF;
  assign special_o     = b_i == 32'd0 || ovf;
  assign special_val_o = b_i == 32'd0 ? (is_rem ? a_i : 32'hFFFF_FFFF) : (is_rem ? 32'd0 : 32'h8000_0000);
  assign abs_a_o       = neg_a ? -a_i : a_i;
  assign abs_b_o       = neg_b ? -b_i : b_i;
  assign result_o      = is_rem ? (neg_a ? -rem_i : rem_i) : (neg_a ^ neg_b ? -quo_i : quo_i);
endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: one-op-at-a-time M-extension controller for shared multiplier and divider.
// MULDIV_ZERO_BYPASS_EN: multiplies with a zero operand finish without starting the multiplier.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int ROB_IDX_W = 5,
  parameter int PHYS_W    = 6
) (
  input logic clk,
  input logic rst,
  muldiv_sequencer_if.master bus
);
  muldiv_state_t        state_q;
  logic [2:0]           funct3_q;
  logic [31:0]          a_q, b_q, div_a_q, div_b_q, cdb_data_q;
  logic [PHYS_W-1:0]    phys_q;
  logic [ROB_IDX_W-1:0] rob_q;
  logic [1:0]           mul_type_q;
  logic                 we_q, mul_start_q, div_start_q, cdb_valid_q, first_q;
  logic                 idle, mul_zero, special;
  logic [31:0]          special_val, abs_a, abs_b, div_res;
  assign idle = state_q == IDLE;
`ifdef MULDIV_ZERO_BYPASS_EN
  assign mul_zero = bus.issue_a == 32'd0 || bus.issue_b == 32'd0;
`else
  assign mul_zero = 1'b0;
`endif
  // In IDLE the fixer sees the offered op so special cases resolve on the accept edge
  muldiv_sign_fix u_sign_fix (
    .op_i         (idle ? bus.issue_funct3[1:0] : funct3_q[1:0]),
    .a_i          (idle ? bus.issue_a : a_q),
    .b_i          (idle ? bus.issue_b : b_q),
    .quo_i        (bus.div_quotient),
    .rem_i        (bus.div_remainder),
    .special_o    (special),
    .special_val_o(special_val),
    .abs_a_o      (abs_a),
    .abs_b_o      (abs_b),
    .result_o     (div_res)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      funct3_q    <= '0;
      a_q         <= '0;
      b_q         <= '0;
      div_a_q     <= '0;
      div_b_q     <= '0;
      cdb_data_q  <= '0;
      phys_q      <= '0;
      rob_q       <= '0;
      we_q        <= 1'b0;
      mul_type_q  <= '0;
      mul_start_q <= 1'b0;
      div_start_q <= 1'b0;
      cdb_valid_q <= 1'b0;
      first_q     <= 1'b0;
    end else if (bus.flush) begin
      state_q     <= IDLE;
      mul_start_q <= 1'b0;
      div_start_q <= 1'b0;
      cdb_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.issue_valid) begin
          funct3_q <= bus.issue_funct3;
          a_q      <= bus.issue_a;
          b_q      <= bus.issue_b;
          phys_q   <= bus.issue_phys_rd;
          rob_q    <= bus.issue_rob_index;
          we_q     <= bus.issue_regf_we;
          div_a_q  <= abs_a;
          div_b_q  <= abs_b;
          if (!bus.issue_funct3[2] && mul_zero) begin
            cdb_data_q  <= '0;
            cdb_valid_q <= 1'b1;
            state_q     <= RESULT;
          end else if (!bus.issue_funct3[2]) begin
            mul_type_q  <= mul_type_of(bus.issue_funct3);
            mul_start_q <= 1'b1;
            state_q     <= MUL_RUN;
          end else if (special) begin
            cdb_data_q  <= special_val;
            cdb_valid_q <= 1'b1;
            state_q     <= RESULT;
          end else begin
            div_start_q <= 1'b1;
            state_q     <= DIV_START;
          end
        end
        MUL_RUN: if (bus.mul_done) begin
          cdb_data_q  <= funct3_q == MUL ? bus.mul_p[31:0] : bus.mul_p[63:32];
          mul_start_q <= 1'b0;
          cdb_valid_q <= 1'b1;
          state_q     <= RESULT;
        end
        DIV_START: begin
          div_start_q <= 1'b0;
          first_q     <= 1'b1;
          state_q     <= DIV_RUN;
        end
        DIV_RUN: begin
          first_q <= 1'b0;
          // divider's complete can still reflect the previous op right after the start pulse
          if (!first_q && bus.div_complete) begin
            cdb_data_q  <= div_res;
            cdb_valid_q <= 1'b1;
            state_q     <= RESULT;
          end
        end
        RESULT: if (bus.cdb_ready) begin
          cdb_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.issue_ready   = idle && !bus.flush && !rst;
  assign bus.mul_start     = mul_start_q;
  assign bus.mul_type      = mul_type_q;
  assign bus.mul_a         = a_q;
  assign bus.mul_b         = b_q;
  assign bus.div_start     = div_start_q;
  assign bus.div_a         = div_a_q;
  assign bus.div_b         = div_b_q;
  assign bus.cdb_valid     = cdb_valid_q;
  assign bus.cdb_data      = cdb_data_q;
  assign bus.cdb_phys_rd   = phys_q;
  assign bus.cdb_rob_index = rob_q;
  assign bus.cdb_regf_we   = we_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed vectors for muldiv_sequencer with behavioural multiplier/divider.
module tb_muldiv_sequencer;
  import muldiv_sequencer_pkg::*;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  muldiv_sequencer_if #(.ROB_IDX_W(5), .PHYS_W(6)) bus ();
  muldiv_sequencer #(.ROB_IDX_W(5), .PHYS_W(6)) dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a, b, exp;
    logic        special;
    logic [31:0] da, db;
    logic [1:0]  mt;
  } vec_t;
  vec_t v[18];
  function automatic logic [63:0] mprod(input logic [1:0] t, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa, sb;
    sa = {{32{t != MUL_UU && a[31]}}, a};
    sb = {{32{t == MUL_SS && b[31]}}, b};
    return sa * sb;
  endfunction
  // multiplier: product three cycles into a held start, cleared by reset or flush
  logic [1:0] mc;
  always @(posedge clk)
    if (rst || bus.flush) begin
      mc <= 2'd0;
      bus.mul_done <= 1'b0;
      bus.mul_p <= 64'd0;
    end else if (bus.mul_start && !bus.mul_done) begin
      mc <= mc + 2'd1;
      if (mc == 2'd2) begin
        bus.mul_done <= 1'b1;
        bus.mul_p <= mprod(bus.mul_type, bus.mul_a, bus.mul_b);
      end
    end else begin
      mc <= 2'd0;
      bus.mul_done <= 1'b0;
    end
  // divider: complete and results stay stale one cycle past a new start
  int dc;
  logic [31:0] dm_a, dm_b;
  always @(posedge clk)
    if (rst) begin
      dc <= 0;
      bus.div_complete <= 1'b0;
      bus.div_quotient <= 32'd0;
      bus.div_remainder <= 32'd0;
    end else if (bus.div_start) begin
      dc <= 5;
      dm_a <= bus.div_a;
      dm_b <= bus.div_b;
    end else if (dc != 0) begin
      dc <= dc - 1;
      bus.div_complete <= (dc == 1);
      if (dc == 1) begin
        bus.div_quotient <= dm_b == 0 ? 32'hFFFF_FFFF : dm_a / dm_b;
        bus.div_remainder <= dm_b == 0 ? dm_a : dm_a % dm_b;
      end
    end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask
  task automatic issue_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input int tag);
    @(negedge clk);
    chk("issue_ready_before_issue", 32'(bus.issue_ready), 32'd1);
    bus.issue_valid = 1'b1;
    bus.issue_funct3 = f3;
    bus.issue_a = a;
    bus.issue_b = b;
    bus.issue_phys_rd = 6'(tag + 1);
    bus.issue_rob_index = 5'(tag);
    bus.issue_regf_we = tag[0];
    @(posedge clk);
    #1 bus.issue_valid = 1'b0;
  endtask
  task automatic wait_valid(output int n, output logic sds, output logic sms,
                            output logic [31:0] ca, output logic [31:0] cb, output logic [1:0] mt);
    n = 0; sds = 1'b0; sms = 1'b0; ca = '0; cb = '0; mt = '0;
    do begin
      @(negedge clk);
      n++;
      if (bus.div_start) begin sds = 1'b1; ca = bus.div_a; cb = bus.div_b; end
      if (bus.mul_start && !sms) begin sms = 1'b1; mt = bus.mul_type; end
    end while (!bus.cdb_valid && n < 60);
    if (!bus.cdb_valid) begin
      checks++;
      errors++;
      $display("FAIL cdb_valid_timeout: got 0 after %0d cycles, required 1", n);
    end
  endtask
  task automatic accept();
    bus.cdb_ready = 1'b1;
    @(posedge clk);
    #1 bus.cdb_ready = 1'b0;
  endtask
  initial begin
    int n;
    logic sds, sms;
    logic [31:0] ca, cb;
    logic [1:0] mt;
    logic [5:0] ep;
    v[0]  = '{MUL,    32'd7,         32'd6,         32'h0000_002A, 1'b0, 32'd0, 32'd0, MUL_SS};
    v[1]  = '{MULH,   32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 1'b0, 32'd0, 32'd0, MUL_SS};
    v[2]  = '{MULHU,  32'hFFFF_FFFF, 32'd2,         32'h0000_0001, 1'b0, 32'd0, 32'd0, MUL_UU};
    v[3]  = '{MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 1'b0, 32'd0, 32'd0, MUL_SU};
    v[4]  = '{MUL,    32'd0,         32'd5,         32'd0,         1'b0, 32'd0, 32'd0, MUL_SS};
    v[5]  = '{MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 32'd0, 32'd0, MUL_SS};
    v[6]  = '{MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 32'd0, 32'd0, MUL_SU};
    v[7]  = '{DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0, 32'd7, 32'd2, MUL_UU};
    v[8]  = '{REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0, 32'd7, 32'd2, MUL_UU};
    v[9]  = '{DIVU,   32'd100,       32'd7,         32'd14,        1'b0, 32'd100, 32'd7, MUL_UU};
    v[10] = '{REMU,   32'd100,       32'd7,         32'd2,         1'b0, 32'd100, 32'd7, MUL_UU};
    v[11] = '{DIV,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 32'd7, 32'd2, MUL_UU};
    v[12] = '{REM,    32'd7,         32'hFFFF_FFFE, 32'd1,         1'b0, 32'd7, 32'd2, MUL_UU};
    v[13] = '{DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 1'b1, 32'd0, 32'd0, MUL_UU};
    v[14] = '{REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b1, 32'd0, 32'd0, MUL_UU};
    v[15] = '{DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 32'd0, 32'd0, MUL_UU};
    v[16] = '{REMU,   32'd9,         32'd0,         32'd9,         1'b1, 32'd0, 32'd0, MUL_UU};
    v[17] = '{DIV,    32'h8000_0000, 32'd2,         32'hC000_0000, 1'b0, 32'h8000_0000, 32'd2, MUL_UU};
    rst = 1'b1;
    bus.flush = 1'b0; bus.issue_valid = 1'b0; bus.issue_funct3 = '0; bus.issue_a = '0; bus.issue_b = '0;
    bus.issue_phys_rd = '0; bus.issue_rob_index = '0; bus.issue_regf_we = 1'b0; bus.cdb_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_issue_ready", 32'(bus.issue_ready), 32'd0);
    chk("reset_cdb_valid", 32'(bus.cdb_valid), 32'd0);
    chk("reset_mul_start", 32'(bus.mul_start), 32'd0);
    chk("reset_div_start", 32'(bus.div_start), 32'd0);
    chk("reset_cdb_data", bus.cdb_data, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 18; i++) begin
      issue_op(v[i].f3, v[i].a, v[i].b, i);
      wait_valid(n, sds, sms, ca, cb, mt);
      if (bus.cdb_valid) begin
        ep = 6'(i + 1);
        chk($sformatf("v%0d_cdb_data", i), bus.cdb_data, v[i].exp);
        chk($sformatf("v%0d_cdb_phys_rd", i), 32'(bus.cdb_phys_rd), 32'(ep));
        chk($sformatf("v%0d_cdb_rob_index", i), 32'(bus.cdb_rob_index), 32'(i));
        chk($sformatf("v%0d_cdb_regf_we", i), 32'(bus.cdb_regf_we), 32'(i % 2));
        if (v[i].special) begin
          chk($sformatf("v%0d_special_latency", i), 32'(n), 32'd1);
          chk($sformatf("v%0d_special_no_div_start", i), 32'(sds), 32'd0);
        end else if (v[i].f3[2]) begin
          chk($sformatf("v%0d_div_started", i), 32'(sds), 32'd1);
          chk($sformatf("v%0d_div_a", i), ca, v[i].da);
          chk($sformatf("v%0d_div_b", i), cb, v[i].db);
        end else if (sms) begin
          chk($sformatf("v%0d_mul_type", i), 32'(mt), 32'(v[i].mt));
        end
        accept();
      end
    end
    // result held while the CDB stalls
    issue_op(DIVU, 32'd100, 32'd7, 20);
    wait_valid(n, sds, sms, ca, cb, mt);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("hold_cdb_valid", 32'(bus.cdb_valid), 32'd1);
      chk("hold_cdb_data", bus.cdb_data, 32'd14);
      chk("hold_issue_ready", 32'(bus.issue_ready), 32'd0);
    end
    accept();
    // flush an in-flight divide; only the following DIVU may reach the CDB
    issue_op(DIV, 32'hFFFF_FFF9, 32'd2, 21);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.div_start && n < 20);
    if (!bus.div_start) begin
      checks++;
      errors++;
      $display("FAIL flush_div_start_timeout: got 0, required 1");
    end
    repeat (3) @(negedge clk);
    bus.flush = 1'b1;
    #1 chk("flush_issue_ready", 32'(bus.issue_ready), 32'd0);
    @(posedge clk);
    #1 bus.flush = 1'b0;
    @(negedge clk);
    chk("flush_cdb_valid", 32'(bus.cdb_valid), 32'd0);
    chk("flush_div_start", 32'(bus.div_start), 32'd0);
    issue_op(DIVU, 32'd100, 32'd7, 22);
    wait_valid(n, sds, sms, ca, cb, mt);
    chk("flush_next_cdb_data", bus.cdb_data, 32'd14);
    chk("flush_next_rob_index", 32'(bus.cdb_rob_index), 32'd22);
    accept();
    // flush on the same cycle as cdb_ready drops the result
    issue_op(MUL, 32'd3, 32'd4, 23);
    wait_valid(n, sds, sms, ca, cb, mt);
    chk("flushacc_cdb_data", bus.cdb_data, 32'd12);
    bus.flush = 1'b1;
    bus.cdb_ready = 1'b1;
    @(posedge clk);
    #1 begin bus.flush = 1'b0; bus.cdb_ready = 1'b0; end
    @(negedge clk);
    chk("flushacc_cdb_valid", 32'(bus.cdb_valid), 32'd0);
    chk("flushacc_issue_ready", 32'(bus.issue_ready), 32'd1);
    // asynchronous reset in the middle of a multiply
    issue_op(MULH, 32'hFFFF_FFFF, 32'd2, 24);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.mul_start && n < 20);
    chk("midmul_mul_start", 32'(bus.mul_start), 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_mul_start", 32'(bus.mul_start), 32'd0);
    chk("async_rst_mul_type", 32'(bus.mul_type), 32'd0);
    chk("async_rst_mul_a", bus.mul_a, 32'd0);
    chk("async_rst_div_a", bus.div_a, 32'd0);
    chk("async_rst_cdb_data", bus.cdb_data, 32'd0);
    chk("async_rst_cdb_rob_index", 32'(bus.cdb_rob_index), 32'd0);
    chk("async_rst_issue_ready", 32'(bus.issue_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_issue_ready", 32'(bus.issue_ready), 32'd1);
    chk("post_rst_mul_start", 32'(bus.mul_start), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
